mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and divide (restoring).
// One step per clock, 32 steps per operation, result on hi/lo.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [64:0] acc;
    logic [31:0] m;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic        last;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] a_ext;
    logic [32:0] m_ext;
    logic [32:0] booth_sum;
    logic [64:0] mul_next;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_n;
    logic [31:0] quot_n;
    logic [31:0] rem_s;
    logic [31:0] quot_s;

    assign last     = (cnt == 5'd31);
    assign busy     = (state == MULT) || (state == DIV);
    assign done     = (state == FIN);
    assign div_zero = (state == FIN) && dz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_mult)
                    state_next = MULT;
                else if (start_div)
                    state_next = (b_in == 32'd0) ? FIN : DIV;
            end
            MULT, DIV: if (last) state_next = FIN;
            FIN:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        a_mag = a_in[31] ? (~a_in + 32'd1) : a_in;
        b_mag = b_in[31] ? (~b_in + 32'd1) : b_in;
        // 33-bit sum keeps the Booth add exact for m = 0x80000000
        a_ext = {acc[64], acc[64:33]};
        m_ext = {m[31], m};
        booth_sum = a_ext;
        unique case (acc[1:0])
            2'b01:   booth_sum = a_ext + m_ext;
            2'b10:   booth_sum = a_ext - m_ext;
            default: booth_sum = a_ext;
        endcase
        mul_next = {booth_sum, acc[32:1]};
        // divide: acc[63:32] partial remainder, acc[31:0] dividend/quotient
        shifted = {acc[63:32], acc[31]};
        diff    = shifted - {1'b0, m};
        ge      = !diff[32];
        rem_n   = ge ? diff[31:0] : shifted[31:0];
        quot_n  = {acc[30:0], ge};
        rem_s   = neg_r ? (~rem_n + 32'd1) : rem_n;
        quot_s  = neg_q ? (~quot_n + 32'd1) : quot_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= 5'd0;
            acc   <= 65'd0;
            m     <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_mult) begin
                        acc <= {32'd0, b_in, 1'b0};
                        m   <= a_in;
                        cnt <= 5'd0;
                        dz  <= 1'b0;
                    end else if (start_div) begin
                        if (b_in != 32'd0) begin
                            acc   <= {33'd0, a_mag};
                            m     <= b_mag;
                            neg_q <= a_in[31] ^ b_in[31];
                            neg_r <= a_in[31];
                            cnt   <= 5'd0;
                            dz    <= 1'b0;
                        end else begin
                            dz <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc <= mul_next;
                    if (last) begin
                        hi <= mul_next[64:33];
                        lo <= mul_next[32:1];
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DIV: begin
                    acc <= {1'b0, rem_n, quot_n};
                    if (last) begin
                        hi <= rem_s;
                        lo <= quot_s;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, busy,
// ignored starts, divide by zero, overflow and async reset.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    int lat;
    int bcnt;
    bit dzs;
    bit hold;
    bit done2;
    bit seen;

    mult_div_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a start, then sample #1 after each edge until done.
    // lat counts edges including the accepting one.
    task automatic run_op(input logic sm, input logic sd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int inj);
        logic [31:0] ph;
        logic [31:0] pl;
        ph = hi;
        pl = lo;
        lat = 0;
        bcnt = 0;
        dzs = 1'b0;
        hold = 1'b1;
        start_mult = sm;
        start_div = sd;
        a_in = a;
        b_in = b;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) bcnt++;
            if (!done && (hi !== ph || lo !== pl)) hold = 1'b0;
            if (done) begin
                lat = k;
                dzs = div_zero;
                break;
            end
            if (k == inj) begin
                start_div = 1'b1;
                a_in = 32'd1;
                b_in = 32'd1;
            end else begin
                start_div = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        start_div = 1'b0;
        @(posedge clock);
        #1;
        done2 = done;
    endtask

    initial begin
        reset = 1'b0;
        start_mult = 1'b0;
        start_div = 1'b0;
        a_in = 32'd0;
        b_in = 32'd0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // 7 * -3, accepted on first edge after reset release
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 0);
        check("mul1_lat", lat, 33);
        check("mul1_busy", bcnt, 32);
        check("mul1_hold", {31'd0, hold}, 32'd1);
        check("mul1_dz", {31'd0, dzs}, 32'd0);
        check("mul1_hi", hi, 32'hFFFFFFFF);
        check("mul1_lo", lo, 32'hFFFFFFEB);
        check("mul1_pulse", {31'd0, done2}, 32'd0);
        check("mul1_idle", {31'd0, busy}, 32'd0);

        // -7 / 2
        run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 0);
        check("div1_lat", lat, 33);
        check("div1_busy", bcnt, 32);
        check("div1_hold", {31'd0, hold}, 32'd1);
        check("div1_hi", hi, 32'hFFFFFFFF);
        check("div1_lo", lo, 32'hFFFFFFFD);
        check("div1_pulse", {31'd0, done2}, 32'd0);

        // divide by zero keeps the previous result
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
        check("dz_lat", lat, 1);
        check("dz_flag", {31'd0, dzs}, 32'd1);
        check("dz_busy", bcnt, 0);
        check("dz_hi", hi, 32'hFFFFFFFF);
        check("dz_lo", lo, 32'hFFFFFFFD);
        check("dz_clear", {31'd0, div_zero}, 32'd0);

        // overflow divide
        run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        check("ovf_lat", lat, 33);
        check("ovf_dz", {31'd0, dzs}, 32'd0);
        check("ovf_hi", hi, 32'd0);
        check("ovf_lo", lo, 32'h80000000);

        // 100 / -7 = -14 r 2
        run_op(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 0);
        check("div2_hi", hi, 32'd2);
        check("div2_lo", lo, 32'hFFFFFFF2);

        // 1000 * -2000 with a start_div pulse at step 10
        run_op(1'b1, 1'b0, 32'd1000, 32'hFFFFF830, 10);
        check("ign_lat", lat, 33);
        check("ign_hi", hi, 32'hFFFFFFFF);
        check("ign_lo", lo, 32'hFFE17B80);
        check("ign_pulse", {31'd0, done2}, 32'd0);
        check("ign_idle", {31'd0, busy}, 32'd0);

        // both starts: multiply wins, -5 * 6
        run_op(1'b1, 1'b1, 32'hFFFFFFFB, 32'd6, 0);
        check("both_lat", lat, 33);
        check("both_dz", {31'd0, dzs}, 32'd0);
        check("both_hi", hi, 32'hFFFFFFFF);
        check("both_lo", lo, 32'hFFFFFFE2);

        // most negative operands
        run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 0);
        check("mn2_hi", hi, 32'h40000000);
        check("mn2_lo", lo, 32'd0);
        run_op(1'b1, 1'b0, 32'h80000000, 32'd1, 0);
        check("mn1_hi", hi, 32'hFFFFFFFF);
        check("mn1_lo", lo, 32'h80000000);

        // reset at step 15 of a divide
        start_div = 1'b1;
        a_in = 32'd1000;
        b_in = 32'd3;
        @(posedge clock);
        #1;
        start_div = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_done", {31'd0, done}, 32'd0);
        check("ar_dz", {31'd0, div_zero}, 32'd0);
        check("ar_hi", hi, 32'd0);
        check("ar_lo", lo, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("ar_nodone", {31'd0, seen}, 32'd0);
        reset = 1'b1;

        run_op(1'b1, 1'b0, 32'd3, 32'd4, 0);
        check("post_lat", lat, 33);
        check("post_hi", hi, 32'd0);
        check("post_lo", lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
